// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO sequencing unit: FSM encoding, op select and
// HI/LO capture source encodings.
package hilo_unit_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMultRun = 2'd1,
    StDivRun  = 2'd2,
    StDone    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SrcRegA = 2'd0,
    SrcMult = 2'd1,
    SrcDiv  = 2'd2
  } hilo_src_e;

endpackage

// File: rtl/hilo_unit_if.sv
// Signal bundle between hilo_unit, the control unit and the mult/div units.
// slave = hilo_unit side, master = everything driving it.
interface hilo_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              OpStart;
  logic              OpSel;
  logic              HIWrite;
  logic              LOWrite;
  logic [DATA_W-1:0] RegAOut;
  logic              MultCtrl;
  logic              MultDone;
  logic [DATA_W-1:0] MultHIOut;
  logic [DATA_W-1:0] MultLOOut;
  logic              DivCtrl;
  logic              DivDone;
  logic [DATA_W-1:0] DivHIOut;
  logic [DATA_W-1:0] DivLOOut;
  logic              DivZero;
  logic [DATA_W-1:0] HIOut;
  logic [DATA_W-1:0] LOOut;
  logic              HiloBusy;
  logic              HiloDone;
  logic              DivZeroErr;
  logic              TimeoutErr;

  modport slave (
    input  OpStart, OpSel, HIWrite, LOWrite, RegAOut,
    input  MultDone, MultHIOut, MultLOOut,
    input  DivDone, DivHIOut, DivLOOut, DivZero,
    output MultCtrl, DivCtrl, HIOut, LOOut,
    output HiloBusy, HiloDone, DivZeroErr, TimeoutErr
  );

  modport master (
    output OpStart, OpSel, HIWrite, LOWrite, RegAOut,
    output MultDone, MultHIOut, MultLOOut,
    output DivDone, DivHIOut, DivLOOut, DivZero,
    input  MultCtrl, DivCtrl, HIOut, LOOut,
    input  HiloBusy, HiloDone, DivZeroErr, TimeoutErr
  );
endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO storage with per-register enables and a shared source mux.
module hilo_regs
  import hilo_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hi_en,
  input  logic              lo_en,
  input  hilo_src_e         src,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_src, lo_src;

  always_comb begin
    hi_src = wdata;
    lo_src = wdata;
    unique case (src)
      SrcMult: begin
        hi_src = mult_hi;
        lo_src = mult_lo;
      end
      SrcDiv: begin
        hi_src = div_hi;
        lo_src = div_lo;
      end
      default: begin
        hi_src = wdata;
        lo_src = wdata;
      end
    endcase
    hi_d = hi_en ? hi_src : hi_q;
    lo_d = lo_en ? lo_src : lo_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// Sequences one mult/div per request and captures the result into HI/LO.
// Define HILO_TIMEOUT_EN to add a watchdog that aborts a run after TIMEOUT_CYCLES.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef HILO_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 48
`endif
) (
  input logic       clock,
  input logic       reset,
  hilo_unit_if.slave bus
);

  state_e    state_q, state_d;
  logic      mult_ctrl_q, mult_ctrl_d;
  logic      div_ctrl_q, div_ctrl_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      dz_q, dz_d;
  logic      hi_en, lo_en;
  hilo_src_e src;

`ifdef HILO_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
  logic            expired;
  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    mult_ctrl_d = mult_ctrl_q;
    div_ctrl_d  = div_ctrl_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dz_d        = 1'b0;
    hi_en       = 1'b0;
    lo_en       = 1'b0;
    src         = SrcRegA;
`ifdef HILO_TIMEOUT_EN
    cnt_d       = '0;
    to_d        = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        hi_en = bus.HIWrite;
        lo_en = bus.LOWrite;
        if (bus.OpStart) begin
          busy_d = 1'b1;
          if (bus.OpSel == OP_DIV) begin
            state_d    = StDivRun;
            div_ctrl_d = 1'b1;
          end else begin
            state_d     = StMultRun;
            mult_ctrl_d = 1'b1;
          end
        end
      end
      StMultRun: begin
`ifdef HILO_TIMEOUT_EN
        cnt_d = cnt_q + CntW'(1);
`endif
        if (bus.MultDone) begin
          src         = SrcMult;
          hi_en       = 1'b1;
          lo_en       = 1'b1;
          mult_ctrl_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = StDone;
        end
`ifdef HILO_TIMEOUT_EN
        else if (expired) begin
          mult_ctrl_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          to_d        = 1'b1;
          state_d     = StDone;
        end
`endif
      end
      StDivRun: begin
`ifdef HILO_TIMEOUT_EN
        cnt_d = cnt_q + CntW'(1);
`endif
        if (bus.DivDone) begin
          // A zero divisor leaves HI/LO untouched and is flagged instead.
          src        = SrcDiv;
          hi_en      = !bus.DivZero;
          lo_en      = !bus.DivZero;
          dz_d       = bus.DivZero;
          div_ctrl_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = StDone;
        end
`ifdef HILO_TIMEOUT_EN
        else if (expired) begin
          div_ctrl_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          to_d       = 1'b1;
          state_d    = StDone;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      mult_ctrl_q <= 1'b0;
      div_ctrl_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mult_ctrl_q <= mult_ctrl_d;
      div_ctrl_q  <= div_ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
    end
  end

`ifdef HILO_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign bus.TimeoutErr = to_q;
`else
  assign bus.TimeoutErr = 1'b0;
`endif

  hilo_regs #(
    .DATA_W(DATA_W)
  ) u_regs (
    .clock  (clock),
    .reset  (reset),
    .hi_en  (hi_en),
    .lo_en  (lo_en),
    .src    (src),
    .mult_hi(bus.MultHIOut),
    .mult_lo(bus.MultLOOut),
    .div_hi (bus.DivHIOut),
    .div_lo (bus.DivLOOut),
    .wdata  (bus.RegAOut),
    .hi     (bus.HIOut),
    .lo     (bus.LOOut)
  );

  assign bus.MultCtrl   = mult_ctrl_q;
  assign bus.DivCtrl    = div_ctrl_q;
  assign bus.HiloBusy   = busy_q;
  assign bus.HiloDone   = done_q;
  assign bus.DivZeroErr = dz_q;

endmodule
